// File: rtl/ofdm_symbol_mapper.sv
// rtl/ofdm_symbol_mapper.sv - 802.11a Gray-coded constellation mapper with subcarrier tracking
// Optional pilot insertion (52-entry symbol with LFSR-scrambled pilots) under MAPPER_PILOT_EN.
module ofdm_symbol_mapper #(
  parameter int WIDTH     = 8,
  parameter int SCALE     = 16,
  parameter int N_DATA_SC = 48
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Data,
  input  logic             Data_valid,
  output logic             Data_ready,
  input  logic [1:0]       Rate_mode,
  output logic [WIDTH-1:0] I_out,
  output logic [WIDTH-1:0] Q_out,
  output logic             Out_valid,
  output logic [5:0]       Sc_index,
  output logic             Sym_end
);

`ifdef MAPPER_PILOT_EN
  localparam int N_SC = 52;
`else
  localparam int N_SC = N_DATA_SC;
`endif

  logic [5:0] acc;
  logic [2:0] bit_cnt;
  logic [5:0] sc_cnt;
  logic [1:0] mode;

  logic              accept, first_bit, grp_done, emit, last_sc, pilot_now;
  logic [1:0]        eff_mode;
  logic [2:0]        n_bpsc;
  logic [5:0]        grp;
  logic signed [3:0] lvl_i, lvl_q;
  logic signed [31:0] prod_i, prod_q;
  logic [WIDTH-1:0]  i_next, q_next;

  // 16-QAM axis: first bit is the sign, second bit selects inner/outer level
  function automatic logic signed [3:0] qam16_lvl(input logic s, input logic m);
    logic signed [3:0] mag;
    mag = m ? 4'sd1 : 4'sd3;
    return s ? mag : -mag;
  endfunction

  function automatic logic signed [3:0] qam64_lvl(input logic s, input logic m1, input logic m0);
    logic signed [3:0] mag;
    case ({m1, m0})
      2'b00:   mag = 4'sd7;
      2'b01:   mag = 4'sd5;
      2'b11:   mag = 4'sd3;
      default: mag = 4'sd1;
    endcase
    return s ? mag : -mag;
  endfunction

`ifdef MAPPER_PILOT_EN
  logic [6:0] lfsr;
  logic       pilot_slot, pilot_neg;

  always_comb begin
    pilot_slot = (sc_cnt == 6'd5) || (sc_cnt == 6'd19) || (sc_cnt == 6'd32) || (sc_cnt == 6'd46);
    // Pilot polarity {+,+,+,-} scrambled by p_n (tap bit 0 -> +1)
    pilot_neg  = (sc_cnt == 6'd46) ^ (lfsr[6] ^ lfsr[3]);
  end

  assign Data_ready = !pilot_slot;
  assign pilot_now  = pilot_slot && En;
`else
  assign Data_ready = 1'b1;
  assign pilot_now  = 1'b0;
`endif

  always_comb begin
    accept    = Data_valid && Data_ready && En;
    first_bit = (sc_cnt == 6'd0) && (bit_cnt == 3'd0);
    eff_mode  = first_bit ? Rate_mode : mode;
    case (eff_mode)
      2'd0:    n_bpsc = 3'd1;
      2'd1:    n_bpsc = 3'd2;
      2'd2:    n_bpsc = 3'd4;
      default: n_bpsc = 3'd6;
    endcase

    grp = acc;
    for (int k = 0; k < 6; k++) begin
      if (bit_cnt == 3'(k)) grp[k] = Data;
    end
    grp_done = accept && (bit_cnt == n_bpsc - 3'd1);
    emit     = grp_done || pilot_now;
    last_sc  = (sc_cnt == 6'(N_SC - 1));

    case (eff_mode)
      2'd0: begin
        lvl_i = grp[0] ? 4'sd1 : -4'sd1;
        lvl_q = 4'sd0;
      end
      2'd1: begin
        lvl_i = grp[0] ? 4'sd1 : -4'sd1;
        lvl_q = grp[1] ? 4'sd1 : -4'sd1;
      end
      2'd2: begin
        lvl_i = qam16_lvl(grp[0], grp[1]);
        lvl_q = qam16_lvl(grp[2], grp[3]);
      end
      default: begin
        lvl_i = qam64_lvl(grp[0], grp[1], grp[2]);
        lvl_q = qam64_lvl(grp[3], grp[4], grp[5]);
      end
    endcase

`ifdef MAPPER_PILOT_EN
    if (pilot_now) begin
      lvl_i = pilot_neg ? -4'sd1 : 4'sd1;
      lvl_q = 4'sd0;
    end
`endif

    prod_i = 32'(int'(lvl_i) * SCALE);
    prod_q = 32'(int'(lvl_q) * SCALE);
    i_next = prod_i[WIDTH-1:0];
    q_next = prod_q[WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc       <= '0;
      bit_cnt   <= '0;
      sc_cnt    <= '0;
      mode      <= 2'd0;
      I_out     <= '0;
      Q_out     <= '0;
      Out_valid <= 1'b0;
      Sym_end   <= 1'b0;
      Sc_index  <= '0;
    end else if (!En) begin
      acc       <= '0;
      bit_cnt   <= '0;
      sc_cnt    <= '0;
      mode      <= 2'd0;
      I_out     <= '0;
      Q_out     <= '0;
      Out_valid <= 1'b0;
      Sym_end   <= 1'b0;
      Sc_index  <= '0;
    end else begin
      Out_valid <= emit;
      Sym_end   <= emit && last_sc;
      if (accept) begin
        if (first_bit) mode <= Rate_mode;
        if (grp_done) begin
          acc     <= '0;
          bit_cnt <= '0;
        end else begin
          acc     <= grp;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (emit) begin
        I_out    <= i_next;
        Q_out    <= q_next;
        Sc_index <= sc_cnt;
        sc_cnt   <= last_sc ? 6'd0 : sc_cnt + 6'd1;
      end
    end
  end

`ifdef MAPPER_PILOT_EN
  // Pilot scrambler steps once per symbol (x^7 + x^4 + 1)
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr <= 7'h7f;
    end else if (!En) begin
      lfsr <= 7'h7f;
    end else if (emit && last_sc) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
    end
  end
`endif

endmodule

// File: doc/ofdm_symbol_mapper.md
Name: ofdm_symbol_mapper

Overview:
Constellation mapper stage directly downstream of the interleaver in the 802.11a transmit chain.
- Accepts the serial interleaved bit stream.
- Groups N_BPSC bits per subcarrier (1/2/4/6).
- Emits Gray-coded BPSK/QPSK/16-QAM/64-QAM I/Q words, one per data subcarrier.
- Tracks the subcarrier index within each OFDM symbol for the downstream IFFT loader.

Parameters:
WIDTH, 8, signed width of I_out/Q_out.
SCALE, 16, integer multiplier applied to constellation level (±1,±3,±5,±7); requires 7*SCALE <= 2^(WIDTH-1)-1.
N_DATA_SC, 48, data subcarriers per OFDM symbol.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset.
En  input  1  synchronous enable; low clears all state as reset does.
Data  input  1  serial interleaved bit.
Data_valid  input  1  Data is presented this cycle.
Data_ready  output  1  block accepts Data this cycle; Data accepted when Data_valid && Data_ready && En.
Rate_mode  input  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=64-QAM.
I_out  output  WIDTH  signed in-phase value.
Q_out  output  WIDTH  signed quadrature value.
Out_valid  output  1  one-cycle strobe: I_out/Q_out/Sc_index valid.
Sc_index  output  6  subcarrier position of current output within the symbol.
Sym_end  output  1  asserted with Out_valid on the last subcarrier of a symbol.

Behaviour:
- Reset low (async) or En low at a clock edge (sync):
  - I_out=0, Q_out=0, Out_valid=0, Sym_end=0, Sc_index=0, Data_ready=1.
  - Bit accumulator and bit count cleared; any partial group is discarded.
  - Latched mode = BPSK.
- Mode latch: Rate_mode is sampled on the first accepted bit of each symbol (Sc_index counter==0 and bit count==0). Changes mid-symbol are ignored until the next symbol.
- N_BPSC = 1/2/4/6 for modes 0/1/2/3. First accepted bit is b0.
- Accumulation: a bit count increments per accepted bit. When the count reaches N_BPSC, the outputs are registered on that same edge. Out_valid is high for exactly the following cycle, so latency is 1 clock from the last bit of a group. Out_valid is low in every other cycle.
- Gray mapping (level × SCALE):
  - BPSK: I = b0 ? +1 : -1; Q = 0.
  - QPSK: I from b0, Q from b1, each 0→-1, 1→+1.
  - 16-QAM: I from b0b1, Q from b2b3: 00→-3, 01→-1, 11→+1, 10→+3.
  - 64-QAM: I from b0b1b2, Q from b3b4b5: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- I_out/Q_out hold their last value while Out_valid is low.
- Subcarrier counter: counts 0..N_DATA_SC-1 and advances on each output. Sym_end=1 with the output at N_DATA_SC-1; the counter then wraps to 0. No idle cycle is required between symbols.
- Data_valid may drop for any number of cycles mid-group; the partial group is held.
- Back-to-back BPSK at 1 bit/cycle yields continuous Out_valid.
- Without the optional feature, Data_ready is constant 1 outside reset.

Optional Feature:
Macro MAPPER_PILOT_EN.
- Defined:
  - Output order is 52 subcarriers, logical -26..-1,+1..+26. Sc_index runs 0..51; Sym_end is asserted at index 51.
  - Pilots occupy indices 5, 19, 32 and 46 (subcarriers -21, -7, +7, +21).
  - Each pilot is emitted one cycle after the preceding data output, with Data_ready=0 in the cycle the pilot is computed.
  - Pilot I = SCALE × {+1,+1,+1,-1} × p_n; Q=0.
  - p_n comes from a 7-bit LFSR x^7+x^4+1, seeded all-ones on reset or En low. Output bit 0→+1, 1→-1.
  - The LFSR advances once per symbol, at Sym_end. The first symbol uses p0 = +1.
  - If the data group for the index after a pilot completes in the pilot cycle, it cannot, because Data_ready=0 blocks acceptance.
- Undefined:
  - No pilot logic and no LFSR.
  - 48 outputs per symbol; Data_ready tied to 1.

Test Plan:
- Reset low mid-stream, then high -> I_out=Q_out=0, Out_valid=0, Sc_index=0, Data_ready=1; the following BPSK bit 1 gives I=+16.
- BPSK, bits 0,1 on consecutive cycles -> Out_valid on the next two cycles with I=-16 then +16, Q=0.
- 16-QAM, bits b0..b3 = 1,0,0,1 -> one Out_valid, I=+48, Q=-16.
- 64-QAM, bits 1,0,0,0,1,1 -> I=+112, Q=-48.
- QPSK, 96 bits with Rate_mode switched to 3 after bit 40 -> 48 QPSK outputs; Sym_end with Sc_index=47; next symbol starts in 64-QAM at Sc_index=0.
- 16-QAM, two bits accepted then En low for one cycle, then bits 1,0,1,0 -> partial discarded; single output I=+48, Q=+48 at Sc_index=0.
- MAPPER_PILOT_EN set, BPSK continuous -> Data_ready=0 exactly once before index 5; pilot I=+16 at index 5 and I=-16 at index 46; Sym_end at index 51.
